adc0808_emulator: RTL and testbench
===================================

Name: adc0808_emulator

Overview:
- Synthesizable responder model of the ADC0808 converter; the device side of the ALE/START/OE/EOC handshake that our ADC interface drives.
- Stands in for the real chip in simulation benches. Can also be loaded on a second board to drive the interface's pins from programmable channel values.
- Performs a real 8-step successive-approximation sequence against the selected channel value. Presents the result on data_out under OE control.

Parameters:
- STEP_CYCLES, 8: clock cycles per SAR bit trial (conversion = 8*STEP_CYCLES cycles); legal range 1..255.
- SYNC_STAGES, 2: synchronizer depth on ale/start/oe/addr; legal range 2..3.

Ports:
- CLK100MHZ input 1: system clock, all logic on rising edge.
- reset input 1: asynchronous, active-low reset.
- ale input 1: address latch enable from the interface.
- start input 1: start-conversion pulse from the interface.
- oe input 1: output enable from the interface.
- addr input 3: analog channel select.
- ch_values input 64: emulated channel levels; channel n = ch_values[8n+7:8n].
- eoc output 1: end of conversion; high = idle/done, low = converting.
- data_out output 8: output latch when enabled, else 8'h00.
- data_drive output 1: high while data_out is validly driven (pad tri-state enable).

Behaviour:
- Reset (reset low, asynchronous):
  - eoc=1, data_out=0, data_drive=0.
  - Output latch=0, latched address=0, SAR=0.
  - Synchronizers cleared; state=IDLE.
- Input conditioning:
  - ale/start/oe/addr pass through SYNC_STAGES flops, then one edge-detect register.
  - An edge is acted on SYNC_STAGES+1 cycles after the pin change is first sampled (call this T_rec).
- ALE: on a recognised ale rising edge, latch the synced addr. This is legal in any state. It never alters a sample already taken.
- States:
  - IDLE: eoc=1.
    - start rise -> CLEAR.
  - CLEAR: SAR=0, eoc=1.
    - start fall -> CONVERT.
    - On entry, sample = ch_values[latched addr] (captured in the same cycle the fall is recognised).
    - Bit index=7, step counter=0.
  - CONVERT: eoc=0 from the first cycle in this state.
    - Each bit lasts STEP_CYCLES cycles. On the last cycle of bit i: trial = SAR | (1<<i); SAR = (trial <= sample) ? trial : SAR.
    - After bit 0 -> DONE.
  - DONE (one cycle): output latch = SAR; eoc=1 on the following cycle; -> IDLE.
- Total eoc-low time = 8*STEP_CYCLES cycles exactly. The final latch equals the sample value.
- start rise during CONVERT (abort/restart):
  - -> CLEAR next cycle and eoc=1.
  - The output latch keeps the previous result.
  - The partial SAR is discarded.
- start rise during CLEAR: ignored (already clearing).
- ch_values changing during CONVERT has no effect; only the sample taken on the CLEAR->CONVERT transition is used.
- OE control:
  - data_drive = synced oe, registered, so it follows one cycle after oe is recognised.
  - data_out = output latch when data_drive=1, else 8'h00.
  - If the latch updates in DONE while oe is high, data_out shows the new value on the next cycle.
- Simultaneous ale and start rise recognised in the same cycle: the address is latched first. The new address applies to the upcoming sample.
- reset asserted mid-conversion: immediate return to reset values; no partial result is latched.

Test Plan:
1. Reset release, no stimulus -> eoc=1, data_drive=0, data_out=8'h00 indefinitely.
2. ch_values channel 3=8'hA5, addr=3:
   - Stimulus: ale pulse, start pulse 4 cycles wide, then oe high after eoc rises.
   - eoc low exactly 64 cycles (STEP_CYCLES=8), starting 1 cycle after start fall is recognised.
   - data_out=8'hA5 with data_drive=1 one cycle after oe is recognised; returns to 8'h00 when oe drops.
3. Boundaries:
   - Channel 0=8'h00 converts to 8'h00 and channel 7=8'hFF converts to 8'hFF.
   - A mid-scale 8'h80 converts to 8'h80.
4. Abort: convert 8'h11, leave oe high, then convert 8'h22.
   - Re-pulse start 20 cycles into the second conversion.
   - eoc returns high; data_out stays 8'h11.
   - The restarted conversion completes 64 cycles after its start fall and yields 8'h22.
5. Change ch_values channel 2 from 8'h40 to 8'hC0 mid-conversion, and pulse ale with addr=5 mid-conversion -> result is 8'h40. The next conversion uses channel 5.
6. Assert reset 30 cycles into a conversion of 8'h77 while oe is high -> eoc=1 and data_out=8'h00 asynchronously; the latch remains 0 after release.

Source files
------------

// File: rtl/adc0808_emulator.sv
// Device-side model of the ADC0808: ALE/START/OE/EOC handshake with a real
// 8-step successive-approximation conversion against programmable channel levels.
module adc0808_emulator #(
   parameter int unsigned STEP_CYCLES = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        CLK100MHZ,
   input  logic        reset,
   input  logic        ale,
   input  logic        start,
   input  logic        oe,
   input  logic [2:0]  addr,
   input  logic [63:0] ch_values,
   output logic        eoc,
   output logic [7:0]  data_out,
   output logic        data_drive
);

   localparam int unsigned SW     = SYNC_STAGES;
   localparam int unsigned STEP_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CLEAR   = 2'd1,
      ST_CONVERT = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   logic [SW-1:0]       ale_sync_q, ale_sync_d;
   logic [SW-1:0]       start_sync_q, start_sync_d;
   logic [SW-1:0]       oe_sync_q, oe_sync_d;
   logic [SW-1:0][2:0]  addr_sync_q, addr_sync_d;
   logic                ale_prev_q, ale_prev_d;
   logic                start_prev_q, start_prev_d;
   state_t              state_q, state_d;
   logic [2:0]          addr_lat_q, addr_lat_d;
   logic [7:0]          sample_q, sample_d;
   logic [7:0]          sar_q, sar_d;
   logic [2:0]          bit_q, bit_d;
   logic [STEP_W-1:0]   step_q, step_d;
   logic [7:0]          latch_q, latch_d;
   logic                eoc_q, eoc_d;
   logic [7:0]          data_out_q, data_out_d;
   logic                data_drive_q, data_drive_d;

   logic                ale_s, start_s, oe_s;
   logic                ale_rise_c, start_rise_c, start_fall_c;
   logic [7:0]          trial_c;

   always_comb begin
      ale_sync_d   = {ale_sync_q[SW-2:0], ale};
      start_sync_d = {start_sync_q[SW-2:0], start};
      oe_sync_d    = {oe_sync_q[SW-2:0], oe};
      addr_sync_d  = {addr_sync_q[SW-2:0], addr};
      ale_s        = ale_sync_q[SW-1];
      start_s      = start_sync_q[SW-1];
      oe_s         = oe_sync_q[SW-1];
      ale_prev_d   = ale_s;
      start_prev_d = start_s;
      ale_rise_c   = ale_s & ~ale_prev_q;
      start_rise_c = start_s & ~start_prev_q;
      start_fall_c = ~start_s & start_prev_q;
      trial_c      = sar_q | (8'd1 << bit_q);

      state_d    = state_q;
      addr_lat_d = addr_lat_q;
      sample_d   = sample_q;
      sar_d      = sar_q;
      bit_d      = bit_q;
      step_d     = step_q;
      latch_d    = latch_q;

      // ALE is honoured in every state; the new address feeds any sample taken this cycle
      if (ale_rise_c) addr_lat_d = addr_sync_q[SW-1];

      case (state_q)
         ST_IDLE: begin
            if (start_rise_c) state_d = ST_CLEAR;
         end
         ST_CLEAR: begin
            sar_d = 8'd0;
            if (start_fall_c) begin
               state_d  = ST_CONVERT;
               sample_d = ch_values[{addr_lat_d, 3'b000} +: 8];
               bit_d    = 3'd7;
               step_d   = '0;
            end
         end
         ST_CONVERT: begin
            if (start_rise_c) begin
               state_d = ST_CLEAR;
               sar_d   = 8'd0;
            end else if (step_q == STEP_W'(STEP_CYCLES - 1)) begin
               step_d = '0;
               if (trial_c <= sample_q) sar_d = trial_c;
               if (bit_q == 3'd0) state_d = ST_DONE;
               else               bit_d   = bit_q - 3'd1;
            end else begin
               step_d = step_q + STEP_W'(1);
            end
         end
         ST_DONE: begin
            latch_d = sar_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      eoc_d        = (state_d != ST_CONVERT);
      data_drive_d = oe_s;
      data_out_d   = oe_s ? latch_q : 8'h00;
   end

   always_ff @(posedge CLK100MHZ or negedge reset) begin
      if (!reset) begin
         ale_sync_q   <= '0;
         start_sync_q <= '0;
         oe_sync_q    <= '0;
         addr_sync_q  <= '0;
         ale_prev_q   <= 1'b0;
         start_prev_q <= 1'b0;
         state_q      <= ST_IDLE;
         addr_lat_q   <= 3'd0;
         sample_q     <= 8'd0;
         sar_q        <= 8'd0;
         bit_q        <= 3'd7;
         step_q       <= '0;
         latch_q      <= 8'd0;
         eoc_q        <= 1'b1;
         data_out_q   <= 8'd0;
         data_drive_q <= 1'b0;
      end else begin
         ale_sync_q   <= ale_sync_d;
         start_sync_q <= start_sync_d;
         oe_sync_q    <= oe_sync_d;
         addr_sync_q  <= addr_sync_d;
         ale_prev_q   <= ale_prev_d;
         start_prev_q <= start_prev_d;
         state_q      <= state_d;
         addr_lat_q   <= addr_lat_d;
         sample_q     <= sample_d;
         sar_q        <= sar_d;
         bit_q        <= bit_d;
         step_q       <= step_d;
         latch_q      <= latch_d;
         eoc_q        <= eoc_d;
         data_out_q   <= data_out_d;
         data_drive_q <= data_drive_d;
      end
   end

   assign eoc        = eoc_q;
   assign data_out   = data_out_q;
   assign data_drive = data_drive_q;

endmodule

// File: tb/tb_adc0808_emulator.sv
// Bench for adc0808_emulator: randomized channel levels checked against a
// channel-array model of address latching, sampling and handshake timing.
module tb_adc0808_emulator;

   localparam int unsigned STEP = 8;
   localparam int unsigned SYNC = 2;
   localparam int unsigned CONV = 8 * STEP;
   localparam int unsigned LAT  = SYNC + 1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ale, start, oe;
   logic [2:0]  addr;
   logic [63:0] ch_values;
   logic        eoc;
   logic [7:0]  data_out;
   logic        data_drive;

   int errors = 0;
   int checks = 0;

   logic [7:0] m_ch [8];
   logic [2:0] m_addr;
   logic [7:0] m_latch;

   always #5 clk = ~clk;

   adc0808_emulator #(.STEP_CYCLES(STEP), .SYNC_STAGES(SYNC)) dut (
      .CLK100MHZ (clk),
      .reset     (rst_n),
      .ale       (ale),
      .start     (start),
      .oe        (oe),
      .addr      (addr),
      .ch_values (ch_values),
      .eoc       (eoc),
      .data_out  (data_out),
      .data_drive(data_drive)
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_ch(input int n, input logic [7:0] v);
      m_ch[n] = v;
      ch_values[n*8 +: 8] = v;
   endtask

   task automatic pulse_ale(input logic [2:0] a);
      addr = a;
      tick(1);
      ale = 1'b1;
      tick(3);
      ale = 1'b0;
      tick(3);
      m_addr = a;
   endtask

   // Called right after start has been driven low; checks eoc fall latency.
   task automatic wait_fall(input string name);
      int lat;
      lat = 0;
      while (eoc !== 1'b0 && lat < 20) begin
         tick(1);
         lat++;
      end
      checks++;
      if (lat != LAT) begin
         errors++;
         $display("FAIL %s eoc_fall_latency: got %0d cycles, expected %0d", name, lat, LAT);
      end
   endtask

   task automatic wait_rise(input string name, input int already);
      int low;
      low = already;
      while (eoc !== 1'b1 && low < 4000) begin
         tick(1);
         low++;
      end
      checks++;
      if (low != CONV) begin
         errors++;
         $display("FAIL %s eoc_low_time: got %0d cycles, expected %0d", name, low, CONV);
      end
   endtask

   task automatic check_out(input string name);
      checks++;
      if (data_out !== (oe ? m_latch : 8'h00) || data_drive !== oe) begin
         errors++;
         $display("FAIL %s data_out: got %h drive=%b, expected %h drive=%b",
                  name, data_out, data_drive, oe ? m_latch : 8'h00, oe);
      end
   endtask

   task automatic convert(input string name);
      logic [7:0] exp_v;
      start = 1'b1;
      tick(4);
      start = 1'b0;
      exp_v = m_ch[m_addr];
      wait_fall(name);
      wait_rise(name, 0);
      m_latch = exp_v;
      tick(3);
      check_out(name);
   endtask

   task automatic test_reset();
      tick(50);
      for (int i = 0; i < 20; i++) begin
         checks++;
         if (eoc !== 1'b1 || data_drive !== 1'b0 || data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_idle: got eoc=%b drive=%b data=%h, expected 1 0 00",
                     eoc, data_drive, data_out);
         end
         tick(5);
      end
   endtask

   task automatic test_basic_oe();
      set_ch(3, 8'hA5);
      pulse_ale(3'd3);
      convert("basic");
      oe = 1'b1;
      tick(2);
      checks++;
      if (data_drive !== 1'b0) begin
         errors++;
         $display("FAIL oe_early: got drive=%b, expected 0", data_drive);
      end
      tick(1);
      checks++;
      if (data_drive !== 1'b1 || data_out !== 8'hA5) begin
         errors++;
         $display("FAIL oe_on: got drive=%b data=%h, expected 1 a5", data_drive, data_out);
      end
      oe = 1'b0;
      tick(3);
      checks++;
      if (data_drive !== 1'b0 || data_out !== 8'h00) begin
         errors++;
         $display("FAIL oe_off: got drive=%b data=%h, expected 0 00", data_drive, data_out);
      end
   endtask

   task automatic test_boundaries();
      oe = 1'b1;
      set_ch(0, 8'h00);
      pulse_ale(3'd0);
      convert("zero");
      set_ch(7, 8'hFF);
      pulse_ale(3'd7);
      convert("full");
      set_ch(4, 8'h80);
      pulse_ale(3'd4);
      convert("mid");
      oe = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 6; i++) begin
         for (int c = 0; c < 8; c++) set_ch(c, 8'($urandom_range(0, 255)));
         pulse_ale(3'($urandom_range(0, 7)));
         oe = 1'($urandom_range(0, 1));
         convert("random");
      end
      oe = 1'b0;
   endtask

   task automatic test_abort();
      int n;
      logic [7:0] exp_v;
      oe = 1'b1;
      set_ch(1, 8'h11);
      pulse_ale(3'd1);
      convert("abort_first");
      set_ch(1, 8'h22);
      start = 1'b1;
      tick(4);
      start = 1'b0;
      wait_fall("abort_second");
      tick(20);
      start = 1'b1;
      n = 0;
      while (eoc !== 1'b1 && n < 20) begin
         tick(1);
         n++;
      end
      checks++;
      if (n != LAT) begin
         errors++;
         $display("FAIL abort_eoc_rise: got %0d cycles, expected %0d", n, LAT);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (data_out !== 8'h11) begin
            errors++;
            $display("FAIL abort_hold: got %h, expected 11", data_out);
         end
         tick(1);
      end
      start = 1'b0;
      exp_v = m_ch[m_addr];
      wait_fall("abort_restart");
      wait_rise("abort_restart", 0);
      m_latch = exp_v;
      tick(3);
      check_out("abort_result");
      oe = 1'b0;
   endtask

   task automatic test_mid_change();
      logic [7:0] exp_v;
      oe = 1'b1;
      set_ch(2, 8'h40);
      set_ch(5, 8'($urandom_range(0, 255)));
      pulse_ale(3'd2);
      start = 1'b1;
      tick(4);
      start = 1'b0;
      exp_v = m_ch[m_addr];
      wait_fall("mid_change");
      tick(10);
      set_ch(2, 8'hC0);
      pulse_ale(3'd5);
      wait_rise("mid_change", 17);
      m_latch = exp_v;
      tick(3);
      checks++;
      if (data_out !== 8'h40) begin
         errors++;
         $display("FAIL mid_change_result: got %h, expected 40", data_out);
      end
      convert("next_uses_ch5");
      oe = 1'b0;
   endtask

   task automatic test_reset_mid();
      oe = 1'b1;
      set_ch(6, 8'h77);
      pulse_ale(3'd6);
      start = 1'b1;
      tick(4);
      start = 1'b0;
      wait_fall("reset_mid");
      tick(30);
      rst_n = 1'b0;
      #1;
      checks++;
      if (eoc !== 1'b1 || data_out !== 8'h00 || data_drive !== 1'b0) begin
         errors++;
         $display("FAIL reset_async: got eoc=%b data=%h drive=%b, expected 1 00 0",
                  eoc, data_out, data_drive);
      end
      m_latch = 8'h00;
      m_addr  = 3'd0;
      tick(3);
      rst_n = 1'b1;
      tick(6);
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (eoc !== 1'b1 || data_out !== 8'h00 || data_drive !== 1'b1) begin
            errors++;
            $display("FAIL reset_after: got eoc=%b data=%h drive=%b, expected 1 00 1",
                     eoc, data_out, data_drive);
         end
         tick(10);
      end
      oe = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      ale       = 1'b0;
      start     = 1'b0;
      oe        = 1'b0;
      addr      = 3'd0;
      ch_values = '0;
      for (int c = 0; c < 8; c++) m_ch[c] = 8'h00;
      m_addr  = 3'd0;
      m_latch = 8'h00;
      tick(5);
      rst_n = 1'b1;
      test_reset();
      test_basic_oe();
      test_boundaries();
      test_random();
      test_abort();
      test_mid_change();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
